// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // 10^n built from shifts and adds so it folds to a constant at elaboration.
  function automatic logic [39:0] pow10(input int unsigned n);
    logic [39:0] r;
    r = 40'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = (r << 3) + (r << 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] adj_c_o
);

  assign adj_c_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter producing packed BCD plus an LCD-ready
// ASCII string, one input bit per clock behind a start/busy/done handshake.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5,
  parameter int unsigned BLANK  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   ascii,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned ASC_W = 8 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned WP1   = WIDTH + 1;

  // Largest representable decimal value, clipped to the input range when it cannot overflow.
  localparam logic [39:0] MAX_DEC = pow10(DIGITS) - 40'd1;
  localparam logic [39:0] MAX_BIN = (40'd1 << WIDTH) - 40'd1;
  localparam logic [WP1-1:0] OVF_LIMIT = WP1'((MAX_DEC < MAX_BIN) ? MAX_DEC : MAX_BIN);

  function automatic logic [ASC_W-1:0] idle_ascii();
    logic [ASC_W-1:0] r;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[8*i +: 8] = ((BLANK != 0) && (i != 0)) ? ASCII_SPACE : ASCII_ZERO;
    end
    return r;
  endfunction

  localparam logic [ASC_W-1:0] ASCII_RST = idle_ascii();

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [ASC_W-1:0]   ascii_q, ascii_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;
  logic [ASC_W-1:0]   ascii_fin;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .adj_c_o (acc_adj[4*g +: 4])
    );
  end

  // Carry out of the top digit falls off, giving value mod 10^DIGITS.
  assign acc_shift = BCD_W'({acc_adj, sr_q[WIDTH-1]});

  // A digit is shown if it or any higher digit is nonzero; overflow disables blanking.
  for (genvar g = 0; g < DIGITS; g++) begin : g_char
    logic [3:0] dig;
    logic       shown;
    assign dig = acc_shift[4*g +: 4];
    if (g == 0) begin : g_units
      assign shown = 1'b1;
    end else begin : g_upper
      assign shown = (BLANK == 0) || ovf_pend_q || (|acc_shift[BCD_W-1:4*g]);
    end
    assign ascii_fin[8*g +: 8] = shown ? (ASCII_ZERO + {4'h0, dig}) : ASCII_SPACE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ascii_q    <= ASCII_RST;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ascii_q    <= ascii_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ascii_d    = ascii_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sr_d       = bin;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = ({1'b0, bin} > OVF_LIMIT);
          state_d    = ST_SHIFT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shift;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d   = acc_shift;
          ascii_d = ascii_fin;
          ovf_d   = ovf_pend_q;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign bcd   = bcd_q;
  assign ascii = ascii_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three parameterisations share one stimulus stream and
// are compared against table vectors and an arithmetic decimal model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;

  logic        busy_a, done_a, ovf_a;
  logic [19:0] bcd_a;
  logic [39:0] ascii_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] bcd_b;
  logic [31:0] ascii_b;
  logic        busy_c, done_c, ovf_c;
  logic [19:0] bcd_c;
  logic [39:0] ascii_c;

  int checks = 0;
  int errors = 0;
  int lat, bcnt, extra;
  int unsigned rv;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ascii(ascii_a), .ovf(ovf_a));

  bin2bcd_seq #(.WIDTH(16), .DIGITS(4), .BLANK(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ascii(ascii_b), .ovf(ovf_b));

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .ascii(ascii_c), .ovf(ovf_c));

  typedef struct {
    logic [15:0] v;
    logic [19:0] bcd;
    logic [39:0] ascii;
    logic        ovf;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Decimal reference: value mod 10^nd split into digits, blanking above the leading digit.
  function automatic void ref_conv(input int unsigned v, input int unsigned nd, input bit blank,
                                   output logic [19:0] rb, output logic [39:0] ra, output bit rovf);
    longint unsigned p, m;
    int unsigned dg [5];
    int msd;
    p = 1;
    for (int i = 0; i < int'(nd); i++) p = p * 10;
    rovf = (longint'(v) >= p);
    m = longint'(v) % p;
    msd = 0;
    rb = '0;
    ra = '0;
    for (int i = 0; i < int'(nd); i++) begin
      dg[i] = int'(m % 10);
      m = m / 10;
      if (dg[i] != 0) msd = i;
    end
    for (int i = 0; i < int'(nd); i++) begin
      rb[4*i +: 4] = 4'(dg[i]);
      ra[8*i +: 8] = (blank && !rovf && i > msd) ? 8'h20 : 8'h30 + 8'(dg[i]);
    end
  endfunction

  task automatic check_model(input int unsigned v, input string tag);
    logic [19:0] eb;
    logic [39:0] ea;
    bit eo;
    ref_conv(v, 5, 1'b1, eb, ea, eo);
    chk({tag, " a.bcd"}, 64'(bcd_a), 64'(eb));
    chk({tag, " a.ascii"}, 64'(ascii_a), 64'(ea));
    chk({tag, " a.ovf"}, 64'(ovf_a), 64'(eo));
    ref_conv(v, 4, 1'b1, eb, ea, eo);
    chk({tag, " b.bcd"}, 64'(bcd_b), 64'(eb[15:0]));
    chk({tag, " b.ascii"}, 64'(ascii_b), 64'(ea[31:0]));
    chk({tag, " b.ovf"}, 64'(ovf_b), 64'(eo));
    ref_conv(v, 5, 1'b0, eb, ea, eo);
    chk({tag, " c.bcd"}, 64'(bcd_c), 64'(eb));
    chk({tag, " c.ascii"}, 64'(ascii_c), 64'(ea));
  endtask

  // Pulses (or holds) start with value v and waits for done, counting cycles and busy cycles.
  task automatic start_and_wait(input logic [15:0] v, input bit hold, output int l, output int b);
    logic [19:0] prev;
    prev = bcd_a;
    start = 1'b1;
    bin = v;
    l = 0;
    b = 0;
    tick();
    l = 1;
    if (busy_a) b++;
    chk("bcd held at start", 64'(bcd_a), 64'(prev));
    if (hold) bin = 16'($urandom);
    else start = 1'b0;
    while (!done_a && l < 60) begin
      tick();
      l++;
      if (busy_a) b++;
      if (hold) bin = 16'($urandom);
    end
    start = 1'b0;
    chk("done aligned b/c", 64'({done_b, done_c}), 64'(2'b11));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " busy"}, 64'(busy_a), 64'd0);
    chk({tag, " done"}, 64'({done_a, done_b, done_c}), 64'd0);
    chk({tag, " bcd"}, 64'({bcd_a, bcd_b, bcd_c}), 64'd0);
    chk({tag, " ovf"}, 64'({ovf_a, ovf_b, ovf_c}), 64'd0);
    chk({tag, " a.ascii"}, 64'(ascii_a), 64'(40'h2020202030));
    chk({tag, " b.ascii"}, 64'(ascii_b), 64'(32'h20202030));
    chk({tag, " c.ascii"}, 64'(ascii_c), 64'(40'h3030303030));
  endtask

  initial begin
    tbl[0] = '{16'd0,     20'h00000, "    0", 1'b0};
    tbl[1] = '{16'd65535, 20'h65535, "65535", 1'b0};
    tbl[2] = '{16'd1234,  20'h01234, " 1234", 1'b0};
    tbl[3] = '{16'd7,     20'h00007, "    7", 1'b0};
    tbl[4] = '{16'd500,   20'h00500, "  500", 1'b0};
    tbl[5] = '{16'd10000, 20'h10000, "10000", 1'b0};
    tbl[6] = '{16'd90,    20'h00090, "   90", 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      start_and_wait(tbl[i].v, 1'b0, lat, bcnt);
      chk("latency", 64'(lat), 64'd17);
      chk("busy cycles", 64'(bcnt), 64'd16);
      chk("tbl bcd", 64'(bcd_a), 64'(tbl[i].bcd));
      chk("tbl ascii", 64'(ascii_a), 64'(tbl[i].ascii));
      chk("tbl ovf", 64'(ovf_a), 64'(tbl[i].ovf));
      check_model(32'(tbl[i].v), "tbl");
      tick();
      chk("done single pulse", 64'(done_a), 64'd0);
    end

    // Back-to-back: second start presented during the DONE cycle.
    start_and_wait(16'd1234, 1'b0, lat, bcnt);
    chk("b2b first bcd", 64'(bcd_a), 64'(20'h01234));
    chk("b2b first ascii", 64'(ascii_a), 64'(" 1234"));
    start_and_wait(16'd7, 1'b0, lat, bcnt);
    chk("b2b second latency", 64'(lat), 64'd17);
    chk("b2b second bcd", 64'(bcd_a), 64'(20'h00007));
    chk("b2b second ascii", 64'(ascii_a), 64'("    7"));
    tick();
    chk("b2b done drop", 64'(done_a), 64'd0);

    // Overflow on the 4-digit instance, then recovery.
    start_and_wait(16'd12345, 1'b0, lat, bcnt);
    chk("ovf b.ovf", 64'(ovf_b), 64'd1);
    chk("ovf b.bcd", 64'(bcd_b), 64'(16'h2345));
    chk("ovf b.ascii", 64'(ascii_b), 64'("2345"));
    chk("ovf a.bcd", 64'(bcd_a), 64'(20'h12345));
    start_and_wait(16'd9999, 1'b0, lat, bcnt);
    chk("9999 b.ovf", 64'(ovf_b), 64'd0);
    chk("9999 b.bcd", 64'(bcd_b), 64'(16'h9999));

    // start held high with bin toggling through the whole conversion.
    start_and_wait(16'd500, 1'b1, lat, bcnt);
    chk("held latency", 64'(lat), 64'd17);
    extra = 0;
    repeat (25) begin
      tick();
      if (done_a) extra++;
    end
    chk("held extra dones", 64'(extra), 64'd0);
    chk("held a.bcd", 64'(bcd_a), 64'(20'h00500));
    chk("held c.ascii", 64'(ascii_c), 64'("00500"));
    chk("held a.ascii", 64'(ascii_a), 64'("  500"));

    // Random values plus decimal boundaries against the model.
    for (int i = 0; i < 36; i++) begin
      case (i)
        0: rv = 9999;
        1: rv = 10000;
        2: rv = 99;
        3: rv = 100;
        4: rv = 1;
        5: rv = 65534;
        default: rv = $urandom_range(0, 65535);
      endcase
      start_and_wait(16'(rv), 1'b0, lat, bcnt);
      chk("rand latency", 64'(lat), 64'd17);
      check_model(rv, "rand");
    end

    // Reset in the middle of a conversion after leaving ovf/bcd nonzero.
    start_and_wait(16'd54321, 1'b0, lat, bcnt);
    chk("pre-reset b.ovf", 64'(ovf_b), 64'd1);
    start = 1'b1;
    bin = 16'd4321;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("mid busy before reset", 64'(busy_a), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("mid reset");
    extra = 0;
    repeat (25) begin
      tick();
      if (done_a || done_b || done_c) extra++;
    end
    chk("no done after reset", 64'(extra), 64'd0);
    start_and_wait(16'd999, 1'b0, lat, bcnt);
    chk("post-reset latency", 64'(lat), 64'd17);
    check_model(999, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
